multi_lane_pattern_generator: RTL and testbench

Parametrised successor to the single-lane BERT pattern generator. Produces `Lanes*OutBits` bits per cycle from either a rotating user pattern or a run-time-selectable PRBS (PRBS7/15/31). Adds start/stop control, finite bursts, per-lane output inversion and counted single-bit error injection. Sits in the BERT transmit path ahead of the serializer lanes; the checker uses the same polynomials.

---
 rtl/bert_pkg.sv | 28 ++
 rtl/prbs_parallel_step.sv | 30 +++
 rtl/multi_lane_pattern_generator.sv | 122 ++++++++++++
 tb/tb_multi_lane_pattern_generator.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bert_pkg.sv
// bert_pkg: mode encodings, PRBS tap constants and sizing helpers shared by the BERT pattern path.
package bert_pkg;

    typedef enum logic [1:0] {
        MODE_PATT   = 2'd0,
        MODE_PRBS7  = 2'd1,
        MODE_PRBS15 = 2'd2,
        MODE_PRBS31 = 2'd3
    } mode_e;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    localparam int PrbsWidth = 31;

    function automatic int seed_length(input int patt_length);
        return patt_length > PrbsWidth ? patt_length : PrbsWidth;
    endfunction

    // Pattern mode reports L=31 so a seed load checks the full register for lock-up.
    function automatic logic [4:0] tap_len(input mode_e m);
        return m == MODE_PRBS7 ? 5'd7 : m == MODE_PRBS15 ? 5'd15 : 5'd31;
    endfunction

    function automatic logic [4:0] tap_pos(input mode_e m);
        return m == MODE_PRBS7 ? 5'd6 : m == MODE_PRBS15 ? 5'd14 : 5'd28;
    endfunction

endpackage

// File: rtl/prbs_parallel_step.sv
// prbs_parallel_step: advances a Fibonacci LFSR W serial steps in one cycle, first bit to the MSB.
module prbs_parallel_step
    import bert_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [PrbsWidth-1:0] state_in,
    input  logic [4:0]           len,
    input  logic [4:0]           tap,
    output logic [PrbsWidth-1:0] state_out,
    output logic [W-1:0]         bits
);

    logic [PrbsWidth-1:0] s;
    logic [4:0]           msb;
    logic [4:0]           tp;

    always_comb begin
        msb = len - 5'd1;
        tp = tap - 5'd1;
        s = state_in;
        bits = '0;
        for (int i = 0; i < W; i++) begin
            bits[W-1-i] = s[msb];
            s = {s[PrbsWidth-2:0], s[msb] ^ s[tp]};
        end
        state_out = s;
    end

endmodule

// File: rtl/multi_lane_pattern_generator.sv
// multi_lane_pattern_generator: multi-lane pattern/PRBS source with bursts, lane inversion and error injection.
module multi_lane_pattern_generator
    import bert_pkg::*;
#(
    parameter int Lanes     = 4,
    parameter int OutBits   = 16,
    parameter int PattLength = 64,
    parameter int CountBits = 16,
    localparam int W          = Lanes * OutBits,
    localparam int SeedLength = seed_length(PattLength),
    localparam int LaneBits   = Lanes > 1 ? $clog2(Lanes) : 1,
    localparam int PosBits    = OutBits > 1 ? $clog2(OutBits) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [SeedLength-1:0] load_in,
    input  logic [1:0]            mode,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CountBits-1:0]  burst_len,
    input  logic [Lanes-1:0]      lane_inv,
    input  logic                  inj_err,
    input  logic [LaneBits-1:0]   inj_lane,
    input  logic [PosBits-1:0]    inj_pos,
    output logic [W-1:0]          out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           inj_count
);

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [CountBits-1:0] burst_q, burst_d, cnt_q, cnt_d;
    logic [PattLength-1:0] patt_q, patt_d;
    logic [PrbsWidth-1:0] prbs_q, prbs_d, prbs_next, seed_mask;
    logic [W-1:0]         out_q, out_d, prbs_bits, lane_mask, inj_mask;
    logic                 valid_q, valid_d, done_q, done_d, last;
    logic [15:0]          inj_q, inj_d;

    prbs_parallel_step #(.W(W)) u_step (
        .state_in (prbs_q),
        .len      (tap_len(mode_q)),
        .tap      (tap_pos(mode_q)),
        .state_out(prbs_next),
        .bits     (prbs_bits)
    );

    always_comb begin
        seed_mask = (31'h1 << tap_len(mode_e'(mode))) - 31'h1;
        lane_mask = '0;
        for (int k = 0; k < Lanes; k++) lane_mask[k*OutBits +: OutBits] = {OutBits{lane_inv[k]}};
        inj_mask = W'(1) << (int'(inj_lane) * OutBits + int'(inj_pos));
        last = burst_q != '0 && cnt_q + 1'b1 == burst_q;
        state_d = state_q;
        mode_d = mode_q;
        burst_d = burst_q;
        cnt_d = cnt_q;
        patt_d = patt_q;
        prbs_d = prbs_q;
        out_d = out_q;
        valid_d = 1'b0;
        done_d = 1'b0;
        inj_d = inj_q;
        if (state_q == IDLE) begin
            if (load) begin
                patt_d = load_in[PattLength-1:0];
                prbs_d = (load_in[PrbsWidth-1:0] & seed_mask) == '0 ? '1 : load_in[PrbsWidth-1:0];
            end
            if (start && !stop) begin
                state_d = RUN;
                mode_d = mode_e'(mode);
                burst_d = burst_len;
                cnt_d = '0;
            end
        end else begin
            // A stop still registers the word of its own cycle; only the state leaves RUN.
            out_d = (mode_q == MODE_PATT ? patt_q[PattLength-1 -: W] : prbs_bits) ^ lane_mask ^ (inj_err ? inj_mask : '0);
            valid_d = 1'b1;
            done_d = last && !stop;
            inj_d = inj_err && inj_q != 16'hFFFF ? inj_q + 16'd1 : inj_q;
            cnt_d = cnt_q + 1'b1;
            patt_d = mode_q == MODE_PATT ? (patt_q << W) | (patt_q >> (PattLength - W)) : patt_q;
            prbs_d = mode_q == MODE_PATT ? prbs_q : prbs_next;
            state_d = stop || last ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_PATT;
            burst_q <= '0;
            cnt_q   <= '0;
            patt_q  <= '0;
            prbs_q  <= '1;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            inj_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            patt_q  <= patt_d;
            prbs_q  <= prbs_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            inj_q   <= inj_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = state_q == RUN;
    assign done      = done_q;
    assign inj_count = inj_q;

endmodule

// File: tb/tb_multi_lane_pattern_generator.sv
// tb_multi_lane_pattern_generator: randomized run of the default build against a serial reference model,
// plus directed literal checks on a 1x8-lane build.
module tb_multi_lane_pattern_generator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    logic        a_load = 0, a_start = 0, a_stop = 0, a_inj_err = 0;
    logic [63:0] a_load_in = 0;
    logic [1:0]  a_mode = 0;
    logic [15:0] a_burst_len = 0;
    logic [3:0]  a_lane_inv = 0;
    logic [1:0]  a_inj_lane = 0;
    logic [3:0]  a_inj_pos = 0;
    logic [63:0] a_out;
    logic        a_out_valid, a_busy, a_done;
    logic [15:0] a_inj_count;

    logic        b_load = 0, b_start = 0, b_stop = 0, b_inj_err = 0;
    logic [31:0] b_load_in = 0;
    logic [1:0]  b_mode = 0;
    logic [15:0] b_burst_len = 0;
    logic [0:0]  b_lane_inv = 0;
    logic [0:0]  b_inj_lane = 0;
    logic [2:0]  b_inj_pos = 0;
    logic [7:0]  b_out;
    logic        b_out_valid, b_busy, b_done;
    logic [15:0] b_inj_count;

    multi_lane_pattern_generator dut_a (
        .clk(clk), .reset(reset), .load(a_load), .load_in(a_load_in), .mode(a_mode),
        .start(a_start), .stop(a_stop), .burst_len(a_burst_len), .lane_inv(a_lane_inv),
        .inj_err(a_inj_err), .inj_lane(a_inj_lane), .inj_pos(a_inj_pos), .out(a_out),
        .out_valid(a_out_valid), .busy(a_busy), .done(a_done), .inj_count(a_inj_count)
    );

    multi_lane_pattern_generator #(.Lanes(1), .OutBits(8), .PattLength(32)) dut_b (
        .clk(clk), .reset(reset), .load(b_load), .load_in(b_load_in), .mode(b_mode),
        .start(b_start), .stop(b_stop), .burst_len(b_burst_len), .lane_inv(b_lane_inv),
        .inj_err(b_inj_err), .inj_lane(b_inj_lane), .inj_pos(b_inj_pos), .out(b_out),
        .out_valid(b_out_valid), .busy(b_busy), .done(b_done), .inj_count(b_inj_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lfsr_len(input logic [1:0] m);
        return m == 2'd1 ? 7 : m == 2'd2 ? 15 : 31;
    endfunction

    function automatic int lfsr_tap(input logic [1:0] m);
        return m == 2'd1 ? 6 : m == 2'd2 ? 14 : 28;
    endfunction

    // Reference model of the default build: serial LFSR of exactly L bits, run bit by bit.
    bit          m_run;
    logic [63:0] m_out, m_raw, m_patt, m_lmask;
    logic        m_valid, m_done;
    logic [15:0] m_cnt, m_burst, m_made;
    logic [1:0]  m_mode;
    int unsigned m_prbs, m_b, m_l, m_t, m_mask;

    task automatic model_step();
        if (reset) begin
            m_run = 0; m_out = 0; m_raw = 0; m_valid = 0; m_done = 0; m_cnt = 0;
            m_patt = 0; m_prbs = 32'h7fff_ffff; m_mode = 0; m_burst = 0; m_made = 0;
        end else if (m_run) begin
            if (m_mode == 2'd0) m_raw = m_patt; // pattern as wide as the word: rotation by W is identity
            else begin
                m_l = lfsr_len(m_mode);
                m_t = lfsr_tap(m_mode);
                m_mask = (32'd1 << m_l) - 1;
                for (int i = 0; i < 64; i++) begin
                    m_b = (m_prbs >> (m_l - 1)) & 1;
                    m_raw[63-i] = m_b[0];
                    m_prbs = ((m_prbs << 1) | (m_b ^ ((m_prbs >> (m_t - 1)) & 1))) & m_mask;
                end
            end
            m_lmask = 0;
            for (int k = 0; k < 4; k++) if (a_lane_inv[k]) m_lmask[k*16 +: 16] = 16'hFFFF;
            m_out = m_raw ^ m_lmask ^ (a_inj_err ? 64'd1 << (int'(a_inj_lane) * 16 + int'(a_inj_pos)) : 64'd0);
            m_valid = 1;
            m_made = m_made + 16'd1;
            if (a_inj_err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_done = m_burst != 0 && m_made == m_burst && !a_stop;
            if (a_stop || (m_burst != 0 && m_made == m_burst)) m_run = 0;
        end else begin
            m_valid = 0;
            m_done = 0;
            if (a_load) begin
                m_patt = a_load_in;
                m_mask = (32'd1 << lfsr_len(a_mode)) - 1;
                m_prbs = a_load_in[31:0] & m_mask;
                if (m_prbs == 0) m_prbs = m_mask;
            end
            if (a_start && !a_stop) begin
                m_run = 1; m_mode = a_mode; m_burst = a_burst_len; m_made = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) if (cmp_en) begin
        tests++;
        if ({a_out, a_out_valid, a_busy, a_done, a_inj_count} !== {m_out, m_valid, m_run, m_done, m_cnt}) begin
            fails++;
            $display("FAIL model @%0t: out=%h v=%b busy=%b done=%b cnt=%0d, expected out=%h v=%b busy=%b done=%b cnt=%0d",
                     $time, a_out, a_out_valid, a_busy, a_done, a_inj_count, m_out, m_valid, m_run, m_done, m_cnt);
        end
    end

    task automatic rand_cycle(input bit allow_stop, input bit allow_reset);
        a_stop = allow_stop && $urandom_range(0, 29) == 0;
        a_start = $urandom_range(0, 7) == 0;
        a_burst_len = $urandom_range(0, 2) == 0 ? 16'd0 : 16'($urandom_range(1, 20));
        a_load = $urandom_range(0, 9) == 0;
        a_load_in = {$urandom, $urandom};
        a_inj_err = $urandom_range(0, 5) == 0;
        a_inj_lane = 2'($urandom);
        a_inj_pos = 4'($urandom);
        a_lane_inv = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'd0;
        reset = allow_reset && $urandom_range(0, 199) == 0;
        @(negedge clk);
    endtask

    task automatic quiesce();
        a_start = 0; a_load = 0; a_inj_err = 0; a_lane_inv = 0; reset = 0;
        a_stop = 1;
        @(negedge clk);
        a_stop = 0;
    endtask

    logic [7:0]   patt_exp [5] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE};
    logic [255:0] bstream;
    logic [7:0]   sw;
    int unsigned  ss, sb;
    int           per_bad;

    initial begin
        @(negedge clk);
        cmp_en = 1;
        @(negedge clk);
        check("reset_out", a_out, 64'd0);
        check("reset_flags", {a_out_valid, a_busy, a_done}, 64'd0);
        check("reset_count", a_inj_count, 64'd0);
        reset = 0;

        // Pattern burst on the 1x8 build
        b_mode = 0; b_load_in = 32'hDEADBEEF; b_load = 1;
        @(negedge clk);
        b_load = 0; b_start = 1; b_burst_len = 5;
        @(negedge clk);
        b_start = 0;
        check("b_start_busy", {b_busy, b_out_valid}, 64'b10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("b_patt_word%0d", i), b_out, patt_exp[i]);
            check($sformatf("b_patt_flags%0d", i), {b_out_valid, b_done, b_busy}, {61'd0, 1'b1, i == 4, i < 4});
        end
        @(negedge clk);
        check("b_after_burst", {b_out_valid, b_busy, b_done}, 64'd0);

        // PRBS7 from a zero seed on the 1x8 build
        b_mode = 1; b_load_in = 0; b_load = 1;
        @(negedge clk);
        b_load = 0; b_start = 1; b_burst_len = 0;
        @(negedge clk);
        b_start = 0;
        ss = 32'h7f;
        for (int w = 0; w < 32; w++) begin
            @(negedge clk);
            for (int j = 7; j >= 0; j--) begin
                sb = (ss >> 6) & 1;
                sw[j] = sb[0];
                ss = ((ss << 1) | (sb ^ ((ss >> 5) & 1))) & 32'h7f;
            end
            if (w == 0) check("b_prbs7_first", b_out, 64'hFE);
            check($sformatf("b_prbs7_word%0d", w), b_out, sw);
            for (int j = 0; j < 8; j++) bstream[w*8 + 7 - j] = b_out[j];
        end
        per_bad = 0;
        for (int i = 0; i < 129; i++) if (bstream[i] !== bstream[i+127]) per_bad++;
        check("b_prbs7_period", per_bad, 64'd0);
        b_stop = 1;
        @(negedge clk);
        b_stop = 0;

        // Randomized phases on the default build
        for (int p = 0; p < 40; p++) begin
            a_mode = 2'($urandom);
            a_load_in = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a_load_in[30:0] = '0;
            a_load = 1;
            @(negedge clk);
            a_load = 0; a_start = 1; a_burst_len = 16'($urandom_range(0, 20));
            @(negedge clk);
            for (int c = 0; c < 60; c++) rand_cycle(1, 1);
            quiesce();
        end

        // Long continuous PRBS31 run, then stop and a seamless restart
        a_mode = 3; a_load_in = {$urandom, $urandom}; a_load = 1; a_start = 1; a_burst_len = 0;
        @(negedge clk);
        for (int c = 0; c < 10000; c++) begin
            rand_cycle(0, 0);
            a_start = 0; a_load = 0;
        end
        a_inj_err = 0; a_lane_inv = 0; a_stop = 1;
        @(negedge clk);
        a_stop = 0;
        check("stop_busy_valid", {a_busy, a_out_valid}, 64'b01);
        @(negedge clk);
        check("stop_valid_off", a_out_valid, 64'd0);
        a_start = 1; a_burst_len = 0;
        @(negedge clk);
        a_start = 0;
        repeat (20) @(negedge clk);
        quiesce();

        // Single injection at lane 2 bit 5, then lane inversion
        reset = 1;
        @(negedge clk);
        reset = 0; a_mode = 3; a_load_in = {$urandom, $urandom}; a_load = 1; a_start = 1; a_burst_len = 0;
        @(negedge clk);
        a_load = 0; a_start = 0;
        repeat (3) @(negedge clk);
        a_inj_err = 1; a_inj_lane = 2; a_inj_pos = 5;
        @(negedge clk);
        a_inj_err = 0;
        check("inj_bit37", a_out ^ m_raw, 64'h0000_0020_0000_0000);
        check("inj_count_one", a_inj_count, 64'd1);
        a_lane_inv = 4'b0101;
        @(negedge clk);
        a_lane_inv = 0;
        check("lane_inv_0101", a_out ^ m_raw, 64'h0000_FFFF_0000_FFFF);
        quiesce();
        @(negedge clk);
        a_inj_err = 1;
        @(negedge clk);
        a_inj_err = 0;
        check("inj_idle_ignored", a_inj_count, 64'd1);

        // start and stop together in IDLE
        a_start = 1; a_stop = 1;
        @(negedge clk);
        a_start = 0; a_stop = 0;
        check("start_stop_idle", a_busy, 64'd0);
        @(negedge clk);
        check("start_stop_novalid", a_out_valid, 64'd0);

        // reset in the middle of a burst
        a_start = 1; a_burst_len = 10;
        @(negedge clk);
        a_start = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("midreset_out", a_out, 64'd0);
        check("midreset_flags", {a_out_valid, a_busy, a_done}, 64'd0);
        check("midreset_count", a_inj_count, 64'd0);
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
